// File: rtl/fault_mgr.sv
// DTMR fault manager: voting-mode control, per-copy recovery resets, fail latch.
// Define FAULT_MGR_LOG_EN to compile in the rec_cnt recovery counter.
module fault_mgr #(
    parameter int FLT_THR  = 4,
    parameter int RST_LEN  = 8,
    parameter int ACT_HOLD = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trig,
    input  logic [2:0] fault,
    output logic       state,
    output logic [2:0] mod_rst,
    output logic       fail,
    output logic [7:0] rec_cnt
);

    typedef enum logic [1:0] {IDLE, ACTIVE, RECOVER, FAIL} st_t;

    localparam logic [3:0]  THR  = 4'(FLT_THR);
    localparam logic [7:0]  RLEN = 8'(RST_LEN - 1);
    localparam logic [15:0] HOLD = 16'(ACT_HOLD);

    st_t             r_st;
    logic [2:0][3:0] r_cnt;
    logic [3:0]      r_c111;
    logic [15:0]     r_hold;
    logic [7:0]      r_rlen;
    logic [2:0]      r_mask;
    logic            r_state;
    logic            r_fail;

    logic [2:0][3:0] w_cnt_nxt;
    logic [2:0]      w_hit;
    logic [3:0]      w_c111_nxt;
    logic            w_busy;

    always_comb begin
        w_cnt_nxt = '0;
        w_hit     = '0;
        for (int i = 0; i < 3; i++) begin
            if (fault[i])
                w_cnt_nxt[i] = (r_cnt[i] == THR) ? THR : r_cnt[i] + 4'd1;
            w_hit[i] = (w_cnt_nxt[i] == THR);
        end
    end

    assign w_c111_nxt = (&fault)
        ? ((r_c111 == THR) ? THR : r_c111 + 4'd1)
        : 4'd0;
    assign w_busy = trig | (|fault);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_st    <= IDLE;
            r_cnt   <= '0;
            r_c111  <= '0;
            r_hold  <= '0;
            r_rlen  <= '0;
            r_mask  <= '0;
            r_state <= 1'b0;
            r_fail  <= 1'b0;
        end else begin
            unique case (r_st)
                IDLE: begin
                    if (trig) begin
                        r_st    <= ACTIVE;
                        r_hold  <= HOLD;
                        r_state <= 1'b1;
                    end
                end
                ACTIVE: begin
                    r_cnt  <= w_cnt_nxt;
                    r_c111 <= w_c111_nxt;
                    // all-three agreement loss outranks a single-copy recovery
                    if (w_c111_nxt == THR) begin
                        r_st   <= FAIL;
                        r_fail <= 1'b1;
                    end else if (|w_hit) begin
                        r_st   <= RECOVER;
                        r_mask <= w_hit;
                        r_rlen <= RLEN;
                        r_cnt  <= '0;
                        r_c111 <= '0;
                    end else if (w_busy) begin
                        r_hold <= HOLD;
                    end else if (r_hold == 16'd1) begin
                        r_st    <= IDLE;
                        r_hold  <= '0;
                        r_state <= 1'b0;
                    end else begin
                        r_hold <= r_hold - 16'd1;
                    end
                end
                RECOVER: begin
                    if (r_rlen == 8'd0) begin
                        r_st   <= ACTIVE;
                        r_mask <= '0;
                        r_hold <= HOLD;
                    end else begin
                        r_rlen <= r_rlen - 8'd1;
                    end
                end
                FAIL: begin
                    r_st   <= FAIL;
                    r_mask <= '0;
                end
            endcase
        end
    end

    assign state   = r_state;
    assign mod_rst = r_mask;
    assign fail    = r_fail;

`ifdef FAULT_MGR_LOG_EN
    logic [7:0] r_rec;
    logic       w_rec_done;

    assign w_rec_done = (r_st == RECOVER) && (r_rlen == 8'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_rec <= '0;
        else if (w_rec_done && (r_rec != 8'hFF))
            r_rec <= r_rec + 8'd1;
    end

    assign rec_cnt = r_rec;
`else
    assign rec_cnt = 8'd0;
`endif

endmodule

// File: doc/fault_mgr.md
FAULT_MGR -- requirements
Module: fault_mgr

Interface
REQ-001 Parameter FLT_THR, default 4: consecutive flagged cycles before a copy is declared faulty (range 1..15).
REQ-002 Parameter RST_LEN, default 8: cycles for which a copy-reset request is held (range 1..255).
REQ-003 Parameter ACT_HOLD, default 64: quiet cycles in active mode before returning to normal mode (range 1..65535).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 trig  input  1  external hazard request to enter DTMR voting mode.
REQ-007 fault  input  3  voter fault flags {copy1, copy2, copy3}; bit 2 = copy 1.
REQ-008 state  output  1  DTMR state to voter; 1 = voting active.
REQ-009 mod_rst  output  3  per-copy reset request, same bit order as fault.
REQ-010 fail  output  1  sticky flag: no majority persisted.
REQ-011 rec_cnt  output  8  count of completed recoveries.

Function
REQ-012 FSM states SHALL be IDLE, ACTIVE, RECOVER and FAIL.
REQ-013 IDLE: state=0, mod_rst=0; fault ignored; trig=1 -> ACTIVE on the next edge, hold counter loaded with ACT_HOLD.
REQ-014 ACTIVE: state=1; per-copy counter increments (saturating at FLT_THR) while its fault bit is 1 and clears to 0 when it is 0.
REQ-015 ACTIVE: hold counter reloads to ACT_HOLD on any cycle with trig=1 or fault!=0; otherwise it decrements; when it reaches 0 -> IDLE next edge.
REQ-016 ACTIVE: fault==3'b111 for FLT_THR consecutive cycles -> FAIL; this check has priority over REQ-017 in the same cycle.
REQ-017 ACTIVE: any per-copy counter reaching FLT_THR -> RECOVER; a mask of every copy at threshold in that cycle is latched.
REQ-018 RECOVER: state=1, mod_rst=latched mask for exactly RST_LEN cycles, starting the first cycle in RECOVER.
REQ-019 RECOVER: fault and trig are ignored, and all per-copy and 111 counters are held at 0.
REQ-020 RECOVER: after RST_LEN cycles -> ACTIVE; mod_rst=0; hold counter reloaded to ACT_HOLD; rec_cnt increments, saturating at 255.
REQ-021 FAIL: state=1, fail=1, mod_rst=0; exited only by reset.
REQ-022 All outputs SHALL be registered; entry to a state is visible on outputs in the cycle after the triggering edge.
REQ-023 With FLT_THR=4, fault bit high on cycles 0..3 in ACTIVE SHALL produce mod_rst asserted from cycle 4.
REQ-024 An intermittent fault (bit drops for one cycle) SHALL restart that copy's count from 0.

Reset
REQ-025 Reset assertion SHALL asynchronously force IDLE, state=0, mod_rst=0, fail=0, rec_cnt=0 and clear all counters and the mask.
REQ-026 Reset asserted mid-RECOVER SHALL drop mod_rst immediately and discard the pending rec_cnt increment.
REQ-027 Reset deassertion is synchronised externally; the first active edge after release SHALL evaluate IDLE.

Configuration
REQ-028 Macro FAULT_MGR_LOG_EN compiles in the rec_cnt counter.
REQ-029 Without FAULT_MGR_LOG_EN, rec_cnt is tied to 8'd0; all other behaviour is unchanged and the port list is identical.

Verification
REQ-030 Reset, then trig=1 for 1 cycle, fault=0 -> state=1 next cycle; state returns to 0 after 64 quiet cycles.
REQ-031 In ACTIVE, fault=3'b010 for 4 cycles -> mod_rst=3'b010 for 8 cycles, then 0; rec_cnt=1 (0 if macro absent).
REQ-032 In ACTIVE, fault=3'b100 for 3 cycles, 0 for 1 cycle, then 3'b100 for 3 cycles -> mod_rst stays 0.
REQ-033 In ACTIVE, fault=3'b111 for 4 cycles -> fail=1, state=1, mod_rst=0; these hold until rst=0.
REQ-034 Assert rst=0 on the 3rd cycle of RECOVER -> mod_rst=0 and state=0 immediately, rec_cnt=0.
REQ-035 Trigger 300 recoveries -> rec_cnt saturates at 255.
